// File: rtl/mem_access_unit_if.sv
// rtl/mem_access_unit_if.sv - CPU-side request/response bundle for mem_access_unit
interface mem_access_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_err;
    logic [31:0] resp_rdata;

    modport master (
        output req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_err, resp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
        output req_ready, resp_valid, resp_err, resp_rdata
    );
endinterface

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - byte/half/word load-store front end for a byte-enabled word RAM
module mem_access_unit #(
    parameter int RAM_WORDS = 32768
) (
    input  logic                      clk,
    input  logic                      rst,
    mem_access_unit_if.slave          cpu,
    output logic                      ram_wren,
    output logic [29:0]               ram_address,
    output logic [31:0]               ram_data,
    output logic [3:0]                ram_byteena,
    input  logic [31:0]               ram_q
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        RESP    = 2'd2
    } state_t;

    localparam logic [31:0] WORD_LIMIT = 32'(RAM_WORDS);

    state_t      state, state_nxt;
    logic [1:0]  off_q;
    logic [1:0]  size_q;
    logic        signed_q;
    logic        err_q;
    logic [31:0] rdata_q;
    logic [29:0] addr_hold;

    logic        accept;
    logic        align_err;
    logic        range_err;
    logic        req_err;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] load_ext;

    always_comb begin
        align_err = 1'b0;
        case (cpu.req_size)
            2'b00:   align_err = 1'b0;
            2'b01:   align_err = cpu.req_addr[0];
            2'b10:   align_err = (cpu.req_addr[1:0] != 2'b00);
            default: align_err = 1'b1;
        endcase
        range_err = ({2'b00, cpu.req_addr[31:2]} >= WORD_LIMIT);
        req_err   = align_err | range_err;
    end

    // Lane select on the registered RAM output, using the offset/size captured at accept.
    always_comb begin
        ld_byte  = ram_q[8*off_q +: 8];
        ld_half  = off_q[1] ? ram_q[31:16] : ram_q[15:0];
        load_ext = ram_q;
        case (size_q)
            2'b00:   load_ext = {{24{signed_q & ld_byte[7]}}, ld_byte};
            2'b01:   load_ext = {{16{signed_q & ld_half[15]}}, ld_half};
            default: load_ext = ram_q;
        endcase
    end

    always_comb begin
        state_nxt     = state;
        ram_wren      = 1'b0;
        ram_byteena   = 4'b0000;
        ram_data      = 32'h0;
        ram_address   = rst ? 30'h0 : addr_hold;
        cpu.req_ready = (state == IDLE) && !rst;
        accept        = cpu.req_ready && cpu.req_valid;

        case (state)
            IDLE: begin
                if (accept) begin
                    if (req_err) begin
                        state_nxt = RESP;
                    end else begin
                        ram_address = cpu.req_addr[31:2];
                        if (cpu.req_we) begin
                            ram_wren = 1'b1;
                            case (cpu.req_size)
                                2'b00: begin
                                    ram_byteena = 4'b0001 << cpu.req_addr[1:0];
                                    ram_data    = {4{cpu.req_wdata[7:0]}};
                                end
                                2'b01: begin
                                    ram_byteena = cpu.req_addr[1] ? 4'b1100 : 4'b0011;
                                    ram_data    = {2{cpu.req_wdata[15:0]}};
                                end
                                default: begin
                                    ram_byteena = 4'b1111;
                                    ram_data    = cpu.req_wdata;
                                end
                            endcase
                            state_nxt = RESP;
                        end else begin
                            state_nxt = RD_WAIT;
                        end
                    end
                end
            end
            RD_WAIT: state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase

        cpu.resp_valid = (state == RESP) && !rst;
        cpu.resp_err   = cpu.resp_valid & err_q;
        cpu.resp_rdata = cpu.resp_valid ? rdata_q : 32'h0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            off_q     <= 2'b00;
            size_q    <= 2'b00;
            signed_q  <= 1'b0;
            err_q     <= 1'b0;
            rdata_q   <= 32'h0;
            addr_hold <= 30'h0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                off_q    <= cpu.req_addr[1:0];
                size_q   <= cpu.req_size;
                signed_q <= cpu.req_signed;
                err_q    <= req_err;
                rdata_q  <= 32'h0;
                if (!req_err) begin
                    addr_hold <= cpu.req_addr[31:2];
                end
            end
            if (state == RD_WAIT) begin
                rdata_q <= load_ext;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - self-checking bench for mem_access_unit with a byte-level memory model
module tb_mem_access_unit;

    localparam int RAM_WORDS = 32768;

    logic        clk = 1'b0;
    logic        rst;
    logic        ram_wren;
    logic [29:0] ram_address;
    logic [31:0] ram_data;
    logic [3:0]  ram_byteena;
    logic [31:0] ram_q;

    always #5 clk = ~clk;

    mem_access_unit_if bus ();

    mem_access_unit #(.RAM_WORDS(RAM_WORDS)) dut (
        .clk         (clk),
        .rst         (rst),
        .cpu         (bus),
        .ram_wren    (ram_wren),
        .ram_address (ram_address),
        .ram_data    (ram_data),
        .ram_byteena (ram_byteena),
        .ram_q       (ram_q)
    );

    // Byte-enabled RAM with registered address (one-cycle read latency).
    logic [31:0] ram [RAM_WORDS];
    bit          ram_cleared;
    always @(posedge clk) begin
        if (!ram_cleared) begin
            for (int i = 0; i < RAM_WORDS; i++) ram[i] <= 32'h0;
            ram_cleared <= 1'b1;
        end else begin
            for (int k = 0; k < 4; k++)
                if (ram_wren && ram_byteena[k])
                    ram[ram_address[14:0]][8*k +: 8] <= ram_data[8*k +: 8];
            ram_q <= ram[ram_address[14:0]];
        end
    end

    int n_checks = 0;
    int n_pass   = 0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endfunction

    // Reference memory, byte-addressed.
    logic [7:0] ref_mem [int];

    function automatic logic [7:0] ref_byte(input logic [31:0] a);
        return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : 8'h00;
    endfunction

    function automatic void model(input logic we, input logic [1:0] sz, input logic sg,
                                  input logic [31:0] a, input logic [31:0] wd,
                                  output logic err, output logic [31:0] rd,
                                  output logic [3:0] be, output logic [31:0] data);
        int n;
        logic [63:0] v;
        n    = 1 << sz;
        err  = (sz == 2'b11) || ((a % n) != 0) || ((a >> 2) >= RAM_WORDS);
        rd   = 32'h0;
        be   = 4'b0000;
        data = 32'h0;
        if (err) return;
        if (we) begin
            for (int i = 0; i < n; i++) begin
                be[(a % 4) + i] = 1'b1;
                ref_mem[int'(a) + i] = wd[8*i +: 8];
            end
            for (int k = 0; k < 4; k++) data[8*k +: 8] = wd[8*(k % n) +: 8];
        end else begin
            v = 64'h0;
            for (int i = 0; i < n; i++) v = v + (64'(ref_byte(a + i)) << (8*i));
            if (sg && n < 4 && v[8*n-1]) v = v | (~64'h0 << (8*n));
            rd = v[31:0];
        end
    endfunction

    typedef struct {
        bit          timeout;
        int          lat;
        logic        err;
        logic [31:0] rd;
        logic        wren;
        logic [3:0]  be;
        logic [31:0] data;
        logic [29:0] addr;
    } obs_t;

    task automatic send(input logic we, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] wd, output obs_t o);
        int guard;
        o = '{timeout: 1'b0, lat: 0, err: 1'b0, rd: 32'h0, wren: 1'b0, be: 4'h0, data: 32'h0, addr: 30'h0};
        guard = 0;
        @(negedge clk);
        while (!bus.req_ready && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        if (!bus.req_ready) begin
            o.timeout = 1'b1;
            return;
        end
        bus.req_we     = we;
        bus.req_size   = sz;
        bus.req_signed = sg;
        bus.req_addr   = a;
        bus.req_wdata  = wd;
        bus.req_valid  = 1'b1;
        #1;
        o.wren = ram_wren;
        o.be   = ram_byteena;
        o.data = ram_data;
        o.addr = ram_address;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            if (bus.resp_valid) begin
                o.lat = c;
                o.err = bus.resp_err;
                o.rd  = bus.resp_rdata;
                break;
            end
        end
        if (o.lat == 0) o.timeout = 1'b1;
    endtask

    task automatic send_and_model(input logic we, input logic [1:0] sz, input logic sg,
                                  input logic [31:0] a, input logic [31:0] wd);
        obs_t o;
        logic e; logic [31:0] r; logic [3:0] b; logic [31:0] d;
        send(we, sz, sg, a, wd, o);
        model(we, sz, sg, a, wd, e, r, b, d);
        check("rnd_timeout", 32'(o.timeout), 32'h0);
        check("rnd_err", 32'(o.err), 32'(e));
        check("rnd_rdata", o.rd, r);
        check("rnd_latency", o.lat, (we || e) ? 1 : 2);
        check("rnd_wren", 32'(o.wren), 32'(we && !e));
        check("rnd_byteena", 32'(o.be), 32'(b));
        check("rnd_ramdata", o.data, d);
        if (!e) check("rnd_address", 32'(o.addr), a >> 2);
    endtask

    // Every cycle: response fields idle-zero and pulse never longer than one cycle.
    bit   mon_en;
    logic prev_rv = 1'b0;
    always @(negedge clk) begin
        if (mon_en && !rst) begin
            if (!bus.resp_valid)
                check("resp_idle_zero", bus.resp_rdata | {31'h0, bus.resp_err}, 32'h0);
            else
                check("resp_single_pulse", 32'(prev_rv), 32'h0);
        end
        prev_rv <= bus.resp_valid;
    end

    typedef struct {
        logic        we;
        logic [1:0]  sz;
        logic        sg;
        logic [31:0] a;
        logic [31:0] wd;
        logic        err;
        logic [31:0] rd;
        logic [3:0]  be;
        logic [31:0] data;
    } vec_t;

    vec_t vt [18];

    initial begin
        obs_t o;
        logic e; logic [31:0] r; logic [3:0] b; logic [31:0] d;
        logic [31:0] exp_q [$];
        logic [31:0] got_q [$];
        logic [6:0]  ready_pat;
        logic [31:0] b2b_addr [3];
        int idx;

        vt[0]  = '{1'b1, 2'd2, 1'b0, 32'h10,    32'hDEADBEEF, 1'b0, 32'h0,        4'hF, 32'hDEADBEEF};
        vt[1]  = '{1'b1, 2'd0, 1'b0, 32'h13,    32'h000000A5, 1'b0, 32'h0,        4'h8, 32'hA5A5A5A5};
        vt[2]  = '{1'b0, 2'd2, 1'b0, 32'h10,    32'h0,        1'b0, 32'hA5ADBEEF, 4'h0, 32'h0};
        vt[3]  = '{1'b0, 2'd0, 1'b1, 32'h13,    32'h0,        1'b0, 32'hFFFFFFA5, 4'h0, 32'h0};
        vt[4]  = '{1'b0, 2'd0, 1'b0, 32'h13,    32'h0,        1'b0, 32'h000000A5, 4'h0, 32'h0};
        vt[5]  = '{1'b1, 2'd2, 1'b0, 32'h20,    32'h80017FFF, 1'b0, 32'h0,        4'hF, 32'h80017FFF};
        vt[6]  = '{1'b0, 2'd1, 1'b1, 32'h22,    32'h0,        1'b0, 32'hFFFF8001, 4'h0, 32'h0};
        vt[7]  = '{1'b0, 2'd1, 1'b0, 32'h22,    32'h0,        1'b0, 32'h00008001, 4'h0, 32'h0};
        vt[8]  = '{1'b0, 2'd1, 1'b1, 32'h20,    32'h0,        1'b0, 32'h00007FFF, 4'h0, 32'h0};
        vt[9]  = '{1'b1, 2'd1, 1'b0, 32'h21,    32'h00001234, 1'b1, 32'h0,        4'h0, 32'h0};
        vt[10] = '{1'b0, 2'd2, 1'b0, 32'h20,    32'h0,        1'b0, 32'h80017FFF, 4'h0, 32'h0};
        vt[11] = '{1'b0, 2'd2, 1'b0, 32'h22,    32'h0,        1'b1, 32'h0,        4'h0, 32'h0};
        vt[12] = '{1'b0, 2'd3, 1'b0, 32'h20,    32'h0,        1'b1, 32'h0,        4'h0, 32'h0};
        vt[13] = '{1'b0, 2'd2, 1'b0, 32'h20000, 32'h0,        1'b1, 32'h0,        4'h0, 32'h0};
        vt[14] = '{1'b1, 2'd2, 1'b0, 32'h1FFFC, 32'h11223344, 1'b0, 32'h0,        4'hF, 32'h11223344};
        vt[15] = '{1'b0, 2'd2, 1'b0, 32'h1FFFC, 32'h0,        1'b0, 32'h11223344, 4'h0, 32'h0};
        vt[16] = '{1'b1, 2'd1, 1'b0, 32'h12,    32'h0000ABCD, 1'b0, 32'h0,        4'hC, 32'hABCDABCD};
        vt[17] = '{1'b0, 2'd2, 1'b0, 32'h10,    32'h0,        1'b0, 32'hABCDBEEF, 4'h0, 32'h0};

        // Reset with a store presented: nothing may be accepted or written.
        rst            = 1'b1;
        bus.req_valid  = 1'b1;
        bus.req_we     = 1'b1;
        bus.req_size   = 2'd2;
        bus.req_signed = 1'b0;
        bus.req_addr   = 32'h40;
        bus.req_wdata  = 32'hFFFFFFFF;
        repeat (3) @(negedge clk);
        check("rst_req_ready", 32'(bus.req_ready), 32'h0);
        check("rst_resp_valid", 32'(bus.resp_valid), 32'h0);
        check("rst_resp_rdata", bus.resp_rdata | {31'h0, bus.resp_err}, 32'h0);
        check("rst_ram_wren", 32'(ram_wren), 32'h0);
        check("rst_ram_byteena", 32'(ram_byteena), 32'h0);
        check("rst_ram_address", 32'(ram_address), 32'h0);
        check("rst_ram_data", ram_data, 32'h0);
        bus.req_valid = 1'b0;
        rst           = 1'b0;
        mon_en        = 1'b1;

        for (int i = 0; i < 18; i++) begin
            send(vt[i].we, vt[i].sz, vt[i].sg, vt[i].a, vt[i].wd, o);
            model(vt[i].we, vt[i].sz, vt[i].sg, vt[i].a, vt[i].wd, e, r, b, d);
            check($sformatf("vec%0d_timeout", i), 32'(o.timeout), 32'h0);
            check($sformatf("vec%0d_err", i), 32'(o.err), 32'(vt[i].err));
            check($sformatf("vec%0d_rdata", i), o.rd, vt[i].rd);
            check($sformatf("vec%0d_latency", i), o.lat, (vt[i].we || vt[i].err) ? 1 : 2);
            check($sformatf("vec%0d_wren", i), 32'(o.wren), 32'(vt[i].we && !vt[i].err));
            check($sformatf("vec%0d_byteena", i), 32'(o.be), 32'(vt[i].be));
            check($sformatf("vec%0d_ramdata", i), o.data, vt[i].data);
            if (!vt[i].err) check($sformatf("vec%0d_address", i), 32'(o.addr), vt[i].a >> 2);
        end

        // The store presented during reset must not have landed.
        send(1'b0, 2'd2, 1'b0, 32'h40, 32'h0, o);
        check("rst_store_dropped", o.rd, 32'h0);

        // Back-to-back loads with req_valid held high.
        b2b_addr[0] = 32'h10;
        b2b_addr[1] = 32'h20;
        b2b_addr[2] = 32'h13;
        for (int i = 0; i < 3; i++) begin
            model(1'b0, (i == 2) ? 2'd0 : 2'd2, 1'b1, b2b_addr[i], 32'h0, e, r, b, d);
            exp_q.push_back(r);
        end
        idx = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            bus.req_valid  = (idx < 3);
            bus.req_we     = 1'b0;
            bus.req_signed = 1'b1;
            bus.req_size   = (idx == 2) ? 2'd0 : 2'd2;
            bus.req_addr   = b2b_addr[idx % 3];
            if (bus.resp_valid) got_q.push_back(bus.resp_rdata);
            if (c < 7) ready_pat[6 - c] = bus.req_ready;
            if (bus.req_ready && idx < 3) idx++;
        end
        bus.req_valid = 1'b0;
        check("b2b_ready_pattern", 32'(ready_pat), 32'(7'b1001001));
        check("b2b_resp_count", got_q.size(), 3);
        for (int i = 0; i < 3; i++)
            check($sformatf("b2b_resp%0d", i), (i < got_q.size()) ? got_q[i] : 32'hX, exp_q[i]);

        // Reset while a load sits in RD_WAIT.
        @(negedge clk);
        bus.req_we    = 1'b0;
        bus.req_size  = 2'd2;
        bus.req_addr  = 32'h10;
        bus.req_valid = 1'b1;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_ready_low", 32'(bus.req_ready), 32'h0);
        check("midrst_resp_low", 32'(bus.resp_valid), 32'h0);
        rst = 1'b0;
        @(negedge clk);
        check("midrst_ready_after", 32'(bus.req_ready), 32'h1);
        check("midrst_no_resp0", 32'(bus.resp_valid), 32'h0);
        @(negedge clk);
        check("midrst_no_resp1", 32'(bus.resp_valid), 32'h0);
        send_and_model(1'b1, 2'd2, 1'b0, 32'h30, 32'hCAFEF00D);
        send_and_model(1'b0, 2'd2, 1'b0, 32'h30, 32'h0);

        // Randomised traffic against the reference model.
        for (int i = 0; i < 200; i++) begin
            logic [31:0] a;
            int sel;
            sel = $urandom_range(0, 9);
            if (sel < 8)       a = $urandom_range(0, 63);
            else if (sel == 8) a = 32'h1FFF0 + $urandom_range(0, 31);
            else               a = $urandom;
            send_and_model(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                           1'($urandom_range(0, 1)), a, $urandom);
        end

        mon_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Load/store front end between the CPU datapath and the word-addressed, byte-enabled data RAM (port A).
- Accepts byte-addressed byte/half/word requests and converts them into a RAM word address, byte enables and lane-replicated write data.
- Waits out the RAM's one-cycle registered-address read latency, then extracts and sign- or zero-extends the read data.
- Flags misaligned, reserved-size and out-of-range accesses without touching the RAM.

Parameters:
- RAM_WORDS, 32768, number of 32-bit words in the RAM; any word index >= RAM_WORDS is out of range.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- req_valid  input  1  CPU request present
- req_ready  output  1  unit can accept a request this cycle
- req_we  input  1  1 = store, 0 = load
- req_size  input  2  00 byte, 01 half, 10 word, 11 reserved
- req_signed  input  1  load sign-extends when 1, zero-extends when 0
- req_addr  input  32  byte address
- req_wdata  input  32  store data, right-aligned
- resp_valid  output  1  one-cycle response pulse
- resp_err  output  1  request rejected (valid with resp_valid)
- resp_rdata  output  32  extended load data (0 for stores and errors)
- ram_wren  output  1  to RAM wren
- ram_address  output  30  to RAM address (word index)
- ram_data  output  32  to RAM data
- ram_byteena  output  4  to RAM byteena_a
- ram_q  input  32  from RAM q; valid the cycle after the address is presented

Behaviour:
- Byte order is little-endian. Lane k is bits [8k+7:8k] and holds byte offset k = req_addr[1:0].
- States:
  - IDLE: req_ready=1.
  - RD_WAIT: req_ready=0.
  - RESP: req_ready=0.
- Accept: req_valid && req_ready in IDLE (cycle T). All request fields are captured into registers at the end of T.
- Error check, combinational in T. An error occurs if any of the following holds:
  - req_size=11
  - size=half with addr[0]=1
  - size=word with addr[1:0]!=0
  - req_addr[31:2] >= RAM_WORDS
- Error path:
  - No RAM access in T (ram_wren=0).
  - Go to RESP. In T+1: resp_valid=1, resp_err=1, resp_rdata=0.
- Store path, ram_* driven combinationally in T:
  - ram_address=req_addr[31:2], ram_wren=1.
  - ram_byteena: byte = 1<<addr[1:0]; half = addr[1] ? 1100 : 0011; word = 1111.
  - ram_data: byte = {4{wdata[7:0]}}; half = {2{wdata[15:0]}}; word = wdata.
  - Go to RESP. In T+1: resp_valid=1, resp_err=0, resp_rdata=0.
- Load path:
  - In T: ram_address=req_addr[31:2], ram_wren=0, ram_byteena=0000. Go to RD_WAIT.
  - In T+1: ram_q is valid. Select lanes using the captured addr/size and extend per the captured signed flag (byte from bit 7, half from bit 15, word unchanged). Register the result. Go to RESP.
  - In T+2: resp_valid=1, resp_err=0, resp_rdata=extended value.
- RESP always returns to IDLE on the next cycle, so a new request can be accepted in the cycle after resp_valid.
- Throughput: store or error, one request per 2 cycles; load, one per 3 cycles.
- There is no response backpressure. The CPU must take resp_* in the pulse cycle.
- Outside an accepting IDLE cycle: ram_wren=0, ram_byteena=0000, ram_data=0. ram_address holds the last driven value.
- resp_err and resp_rdata are 0 whenever resp_valid=0.
- Reset:
  - While rst=1: state=IDLE, req_ready=0, resp_valid=0, resp_err=0, resp_rdata=0, ram_wren=0, ram_byteena=0000, ram_address=0, ram_data=0.
  - A request presented during reset is not accepted and not written.
  - Reset during RD_WAIT or RESP drops the in-flight response. No resp_valid appears after reset deasserts.
- req_valid while req_ready=0 is ignored. The CPU holds the request until accepted.

Test Plan:
- Word store: addr 0x0000_0010, wdata 0xDEADBEEF -> T: ram_address=4, byteena=1111, ram_data=0xDEADBEEF, wren=1. T+1: resp_valid=1, err=0.
- Byte store then loads at addr 0x13, wdata 0x000000A5:
  - Store -> byteena=1000, ram_data=0xA5A5A5A5.
  - Word load at 0x10 -> rdata=0xA5ADBEEF.
  - Signed byte load at 0x13 -> 0xFFFFFFA5.
  - Unsigned byte load at 0x13 -> 0x000000A5.
- Half loads from word 0x8001_7FFF at addr 0x20:
  - Signed half at 0x22 -> 0xFFFF8001.
  - Unsigned half at 0x22 -> 0x00008001.
  - Signed half at 0x20 -> 0x00007FFF.
  - resp_valid exactly 2 cycles after accept.
- Errors:
  - Half store at 0x21 -> wren stays 0, resp_err=1 at T+1, memory unchanged.
  - Word load at 0x22 -> err.
  - size=11 -> err.
  - addr 0x0002_0000 (word 32768, RAM_WORDS=32768) -> err.
- Back-to-back: req_valid held high with 3 queued loads -> req_ready pattern 1,0,0,1,0,0,1. Each resp_valid is one cycle and ordered.
- Reset mid-load: rst=1 in RD_WAIT for 1 cycle -> no resp_valid afterwards, req_ready=1 the cycle after rst falls, and the next store completes normally.
